// File: rtl/mfp_uart_rx_fifo.sv
// mfp_uart_rx_fifo
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO. It sits in
// front of the SREC parser and absorbs bursts while downstream stalls.
// Framing and overflow problems are reported as sticky flags.
//
// Ports:
//   HCLK        system clock, rising edge
//   HRESET      synchronous active-high reset
//   UART_RX     asynchronous serial line, idle high
//   out_data    byte at the FIFO head (registered)
//   out_valid   FIFO not empty (registered)
//   out_ready   consumer takes out_data this cycle
//   fifo_count  current occupancy (registered)
//   frame_err   sticky: a stop bit was sampled low
//   overflow    sticky: a good byte was dropped because the FIFO was full
//   clear_err   clears both sticky flags
module mfp_uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          UART_RX,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clear_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Synchronizer and receive FSM state
    logic          sync1_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          push_s;
    logic          frame_evt_s;

    // FIFO state
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] next_rd_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          out_valid_r;
    logic [7:0]    out_data_r;
    logic [7:0]    head_nxt_s;
    logic          pop_s;
    logic          full_s;
    logic          do_push_s;
    logic          ovf_evt_s;

    // Error flags
    logic          frame_err_r;
    logic          overflow_r;

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= UART_RX;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
        end
    end

    // Receive FSM next-state logic; sampling happens at mid-bit
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        push_s      = 1'b0;
        frame_evt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Only a true 1->0 transition starts a frame, so a held
                // break level cannot retrigger.
                if (rx_prev_r && !rx_sync_r) begin
                    state_nxt_s = ST_START;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    bit_nxt_s = 3'd0;
                    if (!rx_sync_r) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    shift_nxt_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                        bit_nxt_s   = 3'd0;
                    end else begin
                        bit_nxt_s   = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                    if (rx_sync_r) begin
                        push_s      = 1'b1;
                    end else begin
                        frame_evt_s = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    assign pop_s     = out_valid_r & out_ready;
    assign full_s    = (count_r == OCC_FULL);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push_s = push_s & (~full_s | pop_s);
    assign ovf_evt_s = push_s & full_s & ~pop_s;

    // FIFO next occupancy and next head value
    always_comb begin
        case ({do_push_s, pop_s})
            2'b10:   count_nxt_s = count_r + OCC_ONE;
            2'b01:   count_nxt_s = count_r - OCC_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            next_rd_s = rd_ptr_r + PTR_ONE;
        end else begin
            next_rd_s = rd_ptr_r;
        end
        // The new head is the byte being written whenever it lands exactly
        // where the read pointer will point (FIFO empty after this edge
        // otherwise); out_data is registered so this must be forwarded.
        if (do_push_s && (next_rd_s == wr_ptr_r)) begin
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = mem_r[next_rd_s];
        end
    end

    // FIFO storage write port
    always_ff @(posedge HCLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered head outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r    <= next_rd_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            out_data_r  <= head_nxt_s;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (frame_evt_s) begin
                frame_err_r <= 1'b1;
            end else if (clear_err) begin
                frame_err_r <= 1'b0;
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (clear_err) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign fifo_count = count_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_mfp_uart_rx_fifo.sv
// Directed bench for mfp_uart_rx_fifo with 16 clocks per bit and a 4-entry
// FIFO. Frames are driven bit by bit; bytes popped by the consumer are
// collected at the falling edge and compared against hand-written values.
module tb_mfp_uart_rx_fifo;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int DEPTH    = 4;

    logic       HCLK      = 1'b0;
    logic       HRESET    = 1'b1;
    logic       UART_RX   = 1'b1;
    logic       out_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    int         v0;
    logic [7:0] pop_q[$];

    mfp_uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .UART_RX    (UART_RX),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clear_err  (clear_err)
    );

    always #5 HCLK = ~HCLK;

    // Consumer-side monitor, sampled away from the rising edge
    always @(negedge HCLK) begin
        if (out_valid) begin
            valid_cycles <= valid_cycles + 1;
        end
        if (out_valid && out_ready) begin
            pop_q.push_back(out_data);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx < pop_q.size()) begin
            return {24'd0, pop_q[idx]};
        end else begin
            return 32'hDEAD;
        end
    endfunction

    // Drive one 10-bit frame. ready_pulse raises out_ready only during the
    // push cycle (the 155th clock after the start bit is driven). A
    // non-negative reset_at pulses HRESET for two edges at that clock and
    // checks the reset values before releasing it.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input bit ready_pulse, input int reset_at);
        logic [9:0] fr;
        fr = {stop_val, b, 1'b0};
        for (int i = 0; i < 160; i++) begin
            @(posedge HCLK);
            #1;
            UART_RX = fr[i / 16];
            if (ready_pulse) begin
                out_ready = (i == 154);
            end
            if (reset_at >= 0) begin
                if (i == reset_at) begin
                    HRESET = 1'b1;
                end
                if (i == reset_at + 2) begin
                    check_value("rst_mid_valid", {31'd0, out_valid}, 32'd0);
                    check_value("rst_mid_count", {29'd0, fifo_count}, 32'd0);
                    check_value("rst_mid_data", {24'd0, out_data}, 32'd0);
                    check_value("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
                    check_value("rst_mid_ovf", {31'd0, overflow}, 32'd0);
                    HRESET = 1'b0;
                end
            end
        end
        @(posedge HCLK);
        #1;
        UART_RX = 1'b1;
        tick(3);
    endtask

    initial begin
        // Reset values
        tick(3);
        check_value("rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_count", {29'd0, fifo_count}, 32'd0);
        check_value("rst_data", {24'd0, out_data}, 32'd0);
        check_value("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_value("rst_ovf", {31'd0, overflow}, 32'd0);
        HRESET = 1'b0;
        tick(2);

        // 0x55 with consumer always ready: one-cycle valid pulse
        out_ready = 1'b1;
        pop_q.delete();
        v0 = valid_cycles;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        tick(5);
        check_value("t1_pops", pop_q.size(), 32'd1);
        check_value("t1_data", q_at(0), 32'h55);
        check_value("t1_vcyc", valid_cycles - v0, 32'd1);
        check_value("t1_count", {29'd0, fifo_count}, 32'd0);
        check_value("t1_ferr", {31'd0, frame_err}, 32'd0);
        check_value("t1_ovf", {31'd0, overflow}, 32'd0);

        // 4-cycle low glitch: rejected at mid-start
        v0 = valid_cycles;
        UART_RX = 1'b0;
        tick(4);
        UART_RX = 1'b1;
        tick(30);
        check_value("t2_vcyc", valid_cycles - v0, 32'd0);
        check_value("t2_count", {29'd0, fifo_count}, 32'd0);
        check_value("t2_ferr", {31'd0, frame_err}, 32'd0);

        // 0xA3 with a low stop bit: frame error, byte discarded
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        tick(3);
        check_value("t3_ferr", {31'd0, frame_err}, 32'd1);
        check_value("t3_count", {29'd0, fifo_count}, 32'd0);
        check_value("t3_valid", {31'd0, out_valid}, 32'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check_value("t3_ferr_clr", {31'd0, frame_err}, 32'd0);

        // Five bytes into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, -1);
        end
        tick(3);
        check_value("t4_count", {29'd0, fifo_count}, 32'd4);
        check_value("t4_ovf", {31'd0, overflow}, 32'd1);
        check_value("t4_valid", {31'd0, out_valid}, 32'd1);
        check_value("t4_head", {24'd0, out_data}, 32'h01);
        pop_q.delete();
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        check_value("t4_pops", pop_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("t4_pop%0d", k), q_at(k), 32'(k + 1));
        end
        check_value("t4_count_end", {29'd0, fifo_count}, 32'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check_value("t4_ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO, pop coinciding with the push of 0x77
        pop_q.delete();
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k * 17), 1'b1, 1'b0, -1);
        end
        check_value("t5_full", {29'd0, fifo_count}, 32'd4);
        send_frame(8'h77, 1'b1, 1'b1, -1);
        check_value("t5_count", {29'd0, fifo_count}, 32'd4);
        check_value("t5_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        check_value("t5_pops", pop_q.size(), 32'd5);
        check_value("t5_first", q_at(0), 32'h11);
        check_value("t5_fourth", q_at(3), 32'h44);
        check_value("t5_last", q_at(4), 32'h77);

        // Reset in the middle of a data bit, FIFO holding a byte and a flag set
        send_frame(8'h00, 1'b0, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check_value("t6_pre_count", {29'd0, fifo_count}, 32'd1);
        check_value("t6_pre_ferr", {31'd0, frame_err}, 32'd1);
        send_frame(8'hFC, 1'b1, 1'b0, 40);
        tick(20);
        check_value("t6_post_count", {29'd0, fifo_count}, 32'd0);
        check_value("t6_post_valid", {31'd0, out_valid}, 32'd0);
        check_value("t6_post_ferr", {31'd0, frame_err}, 32'd0);
        pop_q.delete();
        out_ready = 1'b1;
        send_frame(8'hC4, 1'b1, 1'b0, -1);
        tick(5);
        check_value("t6_pops", pop_q.size(), 32'd1);
        check_value("t6_data", q_at(0), 32'hC4);
        check_value("t6_count", {29'd0, fifo_count}, 32'd0);
        check_value("t6_ferr", {31'd0, frame_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
